// File: rtl/symbol_error_counter_if.sv
// Symbol stream and result bus between the error meter and its surroundings.
// The master drives symbols and observes results; the slave is the meter.
interface symbol_error_counter_if #(
   parameter int MAX_DELAY   = 32,
   parameter int WINDOW_LOG2 = 16
);
   logic                         sym_clk_ena;
   logic [1:0]                   tx_syms_i;
   logic [1:0]                   tx_syms_q;
   logic [1:0]                   rx_syms_i;
   logic [1:0]                   rx_syms_q;
   logic                         locked;
   logic [$clog2(MAX_DELAY)-1:0] delay_sel;
   logic [WINDOW_LOG2:0]         error_count_i;
   logic [WINDOW_LOG2:0]         error_count_q;
   logic                         result_valid;

   modport master (
      output sym_clk_ena, tx_syms_i, tx_syms_q, rx_syms_i, rx_syms_q,
      input  locked, delay_sel, error_count_i, error_count_q, result_valid
   );

   modport slave (
      input  sym_clk_ena, tx_syms_i, tx_syms_q, rx_syms_i, rx_syms_q,
      output locked, delay_sel, error_count_i, error_count_q, result_valid
   );
endinterface

// File: rtl/symbol_error_counter.sv
// Symbol error meter: searches the tx->rx latency over a delay line, then
// counts I/Q symbol errors over fixed windows once aligned.
//
// state   | meaning
// SEARCH  | trying delay candidate delay_sel for SEARCH_LEN symbols
// MEASURE | aligned; accumulating errors over 2^WINDOW_LOG2 symbol windows
module symbol_error_counter #(
   parameter int MAX_DELAY     = 32,
   parameter int SEARCH_LEN    = 64,
   parameter int SEARCH_THRESH = 4,
   parameter int WINDOW_LOG2   = 16,
   parameter int LOSS_THRESH   = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   symbol_error_counter_if.slave bus
);
   localparam int DW  = $clog2(MAX_DELAY);
   localparam int CW  = WINDOW_LOG2 + 1;
   localparam int SCW = (SEARCH_LEN > 1) ? $clog2(SEARCH_LEN) : 1;
   localparam int SEW = $clog2(SEARCH_LEN + 1);

   localparam logic [SCW-1:0] SEARCH_LAST = SCW'(SEARCH_LEN - 1);
   localparam logic [SEW-1:0] SEARCH_TH   = SEW'(SEARCH_THRESH);
   localparam logic [CW-1:0]  LOSS_TH     = CW'(LOSS_THRESH);

   typedef enum logic {SEARCH, MEASURE} state_t;

   state_t                 state, state_nxt;
   logic [3:0]             line [MAX_DELAY];
   logic [DW-1:0]          delay_sel;
   logic [SCW-1:0]         search_cnt;
   logic [SEW-1:0]         search_err;
   logic [WINDOW_LOG2-1:0] win_cnt;
   logic [CW-1:0]          acc_i, acc_q, acc_c;
   logic [CW-1:0]          err_cnt_i, err_cnt_q;
   logic                   result_valid;

   logic [3:0]     ref_sym;
   logic           err_i, err_q, err_c;
   logic [SEW-1:0] search_tot;
   logic [CW-1:0]  tot_i, tot_q, tot_c;
   logic           search_end, win_end;
   logic           search_fail, window_done, advance;

   assign ref_sym    = line[delay_sel];
   assign err_i      = (ref_sym[3:2] != bus.rx_syms_i);
   assign err_q      = (ref_sym[1:0] != bus.rx_syms_q);
   assign err_c      = err_i | err_q;
   assign search_tot = search_err + SEW'(err_c);
   assign tot_i      = acc_i + CW'(err_i);
   assign tot_q      = acc_q + CW'(err_q);
   assign tot_c      = acc_c + CW'(err_c);
   assign search_end = (search_cnt == SEARCH_LAST);
   assign win_end    = &win_cnt;

   always_comb begin
      state_nxt   = state;
      search_fail = 1'b0;
      window_done = 1'b0;
      if (bus.sym_clk_ena) begin
         case (state)
            SEARCH: begin
               if (search_end) begin
                  if (search_tot <= SEARCH_TH) state_nxt = MEASURE;
                  else                         search_fail = 1'b1;
               end
            end
            MEASURE: begin
               if (win_end) begin
                  window_done = 1'b1;
                  if (tot_c > LOSS_TH) state_nxt = SEARCH;
               end
            end
            default: state_nxt = SEARCH;
         endcase
      end
   end

   // A failed candidate or a lost lock both move on to the next delay.
   assign advance = search_fail | (window_done & (state_nxt == SEARCH));

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= SEARCH;
         delay_sel    <= '0;
         search_cnt   <= '0;
         search_err   <= '0;
         win_cnt      <= '0;
         acc_i        <= '0;
         acc_q        <= '0;
         acc_c        <= '0;
         err_cnt_i    <= '0;
         err_cnt_q    <= '0;
         result_valid <= 1'b0;
      end else begin
         state        <= state_nxt;
         result_valid <= window_done;
         if (advance) delay_sel <= delay_sel + 1'b1;
         if (bus.sym_clk_ena) begin
            if (state == SEARCH && !search_end) begin
               search_cnt <= search_cnt + 1'b1;
               search_err <= search_tot;
            end else begin
               search_cnt <= '0;
               search_err <= '0;
            end
            if (state == MEASURE && !win_end) begin
               win_cnt <= win_cnt + 1'b1;
               acc_i   <= tot_i;
               acc_q   <= tot_q;
               acc_c   <= tot_c;
            end else begin
               win_cnt <= '0;
               acc_i   <= '0;
               acc_q   <= '0;
               acc_c   <= '0;
            end
            if (window_done) begin
               err_cnt_i <= tot_i;
               err_cnt_q <= tot_q;
            end
         end
      end
   end

   // Contents survive candidate changes; only reset clears them.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < MAX_DELAY; k++) line[k] <= '0;
      end else if (bus.sym_clk_ena) begin
         line[0] <= {bus.tx_syms_i, bus.tx_syms_q};
         for (int k = 1; k < MAX_DELAY; k++) line[k] <= line[k-1];
      end
   end

   assign bus.locked        = (state == MEASURE);
   assign bus.delay_sel     = delay_sel;
   assign bus.error_count_i = err_cnt_i;
   assign bus.error_count_q = err_cnt_q;
   assign bus.result_valid  = result_valid;
endmodule

// File: doc/symbol_error_counter.md
# symbol_error_counter

Bench-side symbol error meter downstream of the receiver. Consumes the receiver's sliced 2-bit I/Q symbols plus the transmitter's mapper-input symbols. Finds the unknown end-to-end latency by searching a programmable delay line. Once locked, counts I and Q symbol errors over fixed windows and latches per-window results for readout and SignalTap.

## Interface

Parameters:
- MAX_DELAY, 32: tx delay-line depth in symbols (power of two); delay_sel range 0..MAX_DELAY-1
- SEARCH_LEN, 64: symbols compared per delay candidate during search
- SEARCH_THRESH, 4: max combined errors in a search run that still declares lock
- WINDOW_LOG2, 16: measurement window = 2^WINDOW_LOG2 symbols
- LOSS_THRESH, 1024: combined errors in one window above which lock is dropped

Ports:
- clk, input, 1: system clock; one clock for the whole block
- reset, input, 1: synchronous, active-high reset
- sym_clk_ena, input, 1: one-clk symbol strobe; all state advances only on it
- tx_syms_i, tx_syms_q, input, 2 each: transmitted symbols, valid on sym_clk_ena
- rx_syms_i, rx_syms_q, input, 2 each: receiver slicer output, valid on sym_clk_ena
- locked, output, 1: high in MEASURE state
- delay_sel, output, log2(MAX_DELAY): current alignment candidate
- error_count_i, error_count_q, output, WINDOW_LOG2+1 each: latched errors of the last completed window
- result_valid, output, 1: one-clk pulse when the error counts update

## Operation

- Delay line: MAX_DELAY entries of {tx_i,tx_q}. Shifts on sym_clk_ena: line[0] <= tx input, line[k] <= line[k-1]. The reference symbol is line[delay_sel]. Total alignment delay = delay_sel+1 symbols.
- Compare, each sym_clk_ena: err_i = (line[delay_sel][3:2] != rx_syms_i); err_q similar. Combined error = err_i | err_q.
- FSM states: SEARCH (reset state) and MEASURE.
- SEARCH:
  - search_cnt (0..SEARCH_LEN-1) increments per symbol; search_err accumulates combined errors.
  - On the symbol where search_cnt = SEARCH_LEN-1, evaluate the total including that symbol:
    - if total <= SEARCH_THRESH, go to MEASURE;
    - else delay_sel increments (wraps MAX_DELAY-1 to 0) and the search counters clear.
  - Delay-line contents are not flushed on a candidate change.
- MEASURE:
  - win_cnt (WINDOW_LOG2 bits) increments per symbol; acc_i/acc_q add err_i/err_q; acc_c adds the combined error.
  - On the symbol where win_cnt wraps to 0, the totals include that symbol:
    - error_count_i/q <= totals and result_valid pulses; accumulators and win_cnt clear.
    - If combined total > LOSS_THRESH, go to SEARCH with delay_sel+1 and cleared search counters.
- Arithmetic: counters are unsigned and WINDOW_LOG2+1 bits wide, so a full window of errors (2^WINDOW_LOG2) fits with no saturation.
- error_count_* hold their value until the next window end. The SEARCH state does not clear them.
- Mid-run reset returns every register to its reset value on the next edge, regardless of state or sym_clk_ena.

## Timing

- Reset values: locked=0, delay_sel=0, error_count_i=error_count_q=0, result_valid=0, delay line all zero, FSM=SEARCH.
- All outputs are registered.
- locked, delay_sel and error_count_* change on the clk edge of the deciding sym_clk_ena.
- result_valid is high for exactly that one clk.
- Latency from a deciding symbol to a visible output: 1 clk.
- Lock time with true delay d (candidate d-1, no errors): d*SEARCH_LEN symbols.
- With sym_clk_ena low, no register other than result_valid (which returns to 0) changes.
- Reset asserted together with sym_clk_ena: reset wins.

## Test plan

1. Bench parameters WINDOW_LOG2=8, SEARCH_LEN=64, SEARCH_THRESH=4. PRBS tx, rx = tx delayed 5 symbols -> locked rises on symbol 320 with delay_sel=4. First result_valid comes 256 symbols later with error_count_i=error_count_q=0.
2. While locked, flip rx_i on 3 symbols and rx_q on 1 symbol within one window -> error_count_i=3, error_count_q=1 for that window only; the next window reads 0/0.
3. While locked, replace rx with an uncorrelated PRBS (LOSS_THRESH=100) -> at window end result_valid pulses with counts ~192, locked falls and delay_sel becomes 5.
4. rx delay 33 symbols (beyond range) -> locked stays 0; delay_sel cycles 0..31 and wraps to 0 after 32*64 symbols.
5. Assert reset for 1 clk mid-window while locked -> next cycle locked=0, delay_sel=0, error_count_*=0; relock follows as in scenario 1.
6. Hold sym_clk_ena low for 1000 clks mid-search -> no state or output changes. Resume -> lock occurs after the same symbol count as an uninterrupted run.
